nanov_muldiv: RTL and testbench
===============================

# nanoV_muldiv

Parametrised bit-serial RISC-V M-extension unit for the nanoV core, replacing the multiply-only unit with all eight M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. Operands stream in LSB-first over XLEN cycles, matching the core's register-file bit order. Computation is a fixed-latency radix-2 shift-add multiply or restoring divide on magnitudes. The XLEN-bit result streams back out LSB-first for the core to write to rd.

## Interface
Parameters:
- XLEN, 32, operand/result width (≥4, power of two)

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled only when busy=0
- op  input  3  funct3 of the instruction; sampled with start
- a_in  input  1  rs1 serial bit, LSB first; bit 0 valid in start cycle
- b_in  input  1  rs2 serial bit, LSB first; bit 0 valid in start cycle
- busy  output  1  operation in progress
- result_valid  output  1  result_out carries a result bit
- result_out  output  1  result serial bit, LSB first

## Operation
- op encoding (funct3):
  - 0 MUL (low XLEN bits of product).
  - 1 MULH (signed×signed, high bits).
  - 2 MULHSU (signed×unsigned, high bits).
  - 3 MULHU (unsigned, high bits).
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- States and transitions:
  - IDLE → LOAD on start & !busy.
  - LOAD (XLEN cycles, including the start cycle) shifts a_in and b_in into XLEN-bit A and B registers, then → SIGN.
  - SIGN (1 cycle):
    - Records neg_a = A[XLEN-1] & signed_a and neg_b = B[XLEN-1] & signed_b.
    - Replaces A and B with their magnitudes (conditional two's complement).
    - → CALC.
  - CALC (XLEN cycles):
    - Multiply: a 2·XLEN product accumulator adds A when the current multiplier bit is 1, then shifts right.
    - Divide: restoring step. Shift {rem, quot} left, trial-subtract B, keep the result if non-negative, set the quotient bit.
    - → FIX.
  - FIX (1 cycle) conditionally negates the selected result, then → OUT.
  - OUT (XLEN cycles) shifts the result out, then → IDLE.
- Signedness:
  - signed_a is set for op 1, 2, 4 and 6.
  - signed_b is set for op 1, 4 and 6.
- Result sign rules:
  - Product: negate the 2·XLEN product when neg_a ^ neg_b.
  - Quotient: negate when neg_a ^ neg_b and divisor ≠ 0.
  - Remainder: negate when neg_a.
- Division boundary cases (must fall out of the datapath, with no special trap):
  - Divide by zero: quotient all ones for DIV and DIVU; remainder = dividend for REM and REMU.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0.
- Arithmetic widths:
  - Magnitudes are XLEN-bit unsigned, so −2^(XLEN−1) maps to 2^(XLEN−1).
  - The product register is 2·XLEN bits.
  - The divider trial subtract is XLEN+1 bits.
- Corner cases:
  - start while busy is ignored; op and operands are not resampled.
  - Reset asserted mid-operation returns to IDLE immediately and the result is discarded.

## Timing
- Cycle numbering: cycle 0 is the start cycle.
  - LOAD: cycles 0..XLEN−1.
  - SIGN: cycle XLEN.
  - CALC: cycles XLEN+1..2·XLEN.
  - FIX: cycle 2·XLEN+1.
  - OUT: cycles 2·XLEN+2..3·XLEN+1.
- busy is registered: high from cycle 1 through the last OUT cycle, low in the cycle after it.
  - A new start is accepted in that same cycle, so back-to-back throughput is one operation per 3·XLEN+2 cycles.
- result_valid is high exactly during OUT. Result bit k is presented in OUT cycle k.
- Latency is independent of operand values and op.
- Reset values: busy=0, result_valid=0, result_out=0; state=IDLE. Datapath registers are don't-care.

## Configuration
- NANOV_MULDIV_DIV_EN, when defined:
  - Division ops 4–7 are implemented.
  - The divider trial subtractor and remainder register are compiled in.
- NANOV_MULDIV_DIV_EN, when undefined:
  - Ops 4–7 follow the identical state sequence and latency but produce result 0.
  - No divider logic is instantiated.

## Structure
- nanoV_muldiv_pkg holds:
  - op code constants (MUL..REMU);
  - the state enum (IDLE, LOAD, SIGN, CALC, FIX, OUT);
  - helper functions is_signed_a(op), is_signed_b(op), is_div(op), is_high(op).
- Sub-module nanoV_cneg: parametrised-width conditional two's-complement negator.
  - Instantiated for the A and B magnitudes in SIGN and for the result in FIX.

## Test plan
- MUL, a=0x00000007, b=0xFFFFFFFD → result 0xFFFFFFEB. result_valid rises in cycle 66 (XLEN=32) and lasts 32 cycles.
- MULH, a=0x80000000, b=0x80000000 → 0x40000000. MULHSU with the same operands → 0xC0000000. MULHU with the same operands → 0x40000000.
- DIV, a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU, a=100, b=7 → 14. REMU with the same operands → 2.
- Divide by zero, a=0x12345678, b=0: DIV and DIVU → 0xFFFFFFFF; REM and REMU → 0x12345678. Overflow DIV, a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Handshake and reset:
  - Pulse start again in cycle 10 → ignored; the original result is unchanged.
  - Assert rstn=0 in cycle 40 → busy=0 and result_valid=0 immediately.
  - After release, a new MULHU of 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Build without NANOV_MULDIV_DIV_EN:
  - DIVU 100/7 → result 0 with unchanged timing.
  - MUL 6×7 → 42.

Source files
------------

// File: rtl/nanov_muldiv_pkg.sv
// Shared definitions for the nanoV bit-serial M-extension unit: op codes, FSM states, op decode helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by importers: NANOV_MULDIV_DIV_EN (division ops 4-7).
package nanov_muldiv_pkg;

    // funct3 encodings of the RV32M/RV64M instructions
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SIGN = 3'd2,
        CALC = 3'd3,
        FIX  = 3'd4,
        OUT  = 3'd5
    } state_t;

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_high(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/nanov_muldiv_cneg.sv
// Conditional two's-complement negator: q = neg ? -d : d, W bits wide.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: d (operand), neg (negate enable), q (result).
module nanov_muldiv_cneg #(
    parameter int W = 32
) (
    input  logic [W-1:0] d,
    input  logic         neg,
    output logic [W-1:0] q
);

    assign q = neg ? (~d + W'(1)) : d;

endmodule

// File: rtl/nanov_muldiv.sv
// Bit-serial RISC-V M unit: LSB-first operands in, shift-add multiply / restoring divide, LSB-first result out.
// Latency: fixed 3*XLEN+2 cycles start-to-idle; result bits in cycles 2*XLEN+2..3*XLEN+1 after start.
// Backpressure: none; start is ignored while busy, the core must wait for busy=0.
// Ports: clk, rstn (async active-low), start/op/a_in/b_in (request), busy, result_valid/result_out (serial result).
// Macro NANOV_MULDIV_DIV_EN compiles in the divider; without it ops 4-7 keep the same timing and return 0.
module nanov_muldiv
    import nanov_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       a_in,
    input  logic       b_in,
    output logic       busy,
    output logic       result_valid,
    output logic       result_out
);

    localparam int             CW       = $clog2(XLEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q;      // operand A; doubles as the quotient shift register when dividing
    logic [XLEN-1:0]     b_q;
    logic                neg_a;
    logic                neg_b;
    logic [2*XLEN-1:0]   prod;     // {accumulator, multiplier}; holds the full product after CALC
    logic [XLEN-1:0]     res;      // outgoing result; bit 0 is the pin

    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic                a_is_neg;
    logic                b_is_neg;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   prod_nxt;
    logic [2*XLEN-1:0]   fix_in;
    logic                fix_neg;
    logic [2*XLEN-1:0]   fixed;
    logic [XLEN-1:0]     res_sel;

`ifdef NANOV_MULDIV_DIV_EN
    logic [XLEN-1:0]     rem;
    logic                b_nz;
    logic [XLEN:0]       trial;

    // rem < B always holds, so the shifted remainder fits XLEN+1 bits and bit XLEN is the borrow
    assign trial = {rem, a_q[XLEN-1]} - {1'b0, b_q};
`endif

    assign a_is_neg = a_q[XLEN-1] & is_signed_a(op_q);
    assign b_is_neg = b_q[XLEN-1] & is_signed_b(op_q);

    nanov_muldiv_cneg #(.W(XLEN)) u_neg_a (
        .d   (a_q),
        .neg (a_is_neg),
        .q   (a_mag)
    );

    nanov_muldiv_cneg #(.W(XLEN)) u_neg_b (
        .d   (b_q),
        .neg (b_is_neg),
        .q   (b_mag)
    );

    // One radix-2 step: add the multiplicand into the top half when the multiplier LSB is set,
    // then shift right keeping the adder carry.
    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    assign prod_nxt = {mul_sum, prod[XLEN-1:1]};

    always_comb begin
        fix_in  = prod;
        fix_neg = neg_a ^ neg_b;
`ifdef NANOV_MULDIV_DIV_EN
        if (is_div(op_q)) begin
            if (is_rem(op_q)) begin
                fix_in  = {{XLEN{1'b0}}, rem};
                fix_neg = neg_a;
            end else begin
                // a zero divisor leaves the all-ones quotient un-negated
                fix_in  = {{XLEN{1'b0}}, a_q};
                fix_neg = (neg_a ^ neg_b) & b_nz;
            end
        end
`endif
    end

    nanov_muldiv_cneg #(.W(2*XLEN)) u_neg_res (
        .d   (fix_in),
        .neg (fix_neg),
        .q   (fixed)
    );

    always_comb begin
        res_sel = is_high(op_q) ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
`ifdef NANOV_MULDIV_DIV_EN
`else
        if (is_div(op_q)) begin
            res_sel = '0;
        end
`endif
    end

    assign result_out = res[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            cnt          <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            neg_a        <= 1'b0;
            neg_b        <= 1'b0;
            prod         <= '0;
            res          <= '0;
`ifdef NANOV_MULDIV_DIV_EN
            rem          <= '0;
            b_nz         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= {a_in, a_q[XLEN-1:1]};
                        b_q   <= {b_in, b_q[XLEN-1:1]};
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    a_q <= {a_in, a_q[XLEN-1:1]};
                    b_q <= {b_in, b_q[XLEN-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    neg_a <= a_is_neg;
                    neg_b <= b_is_neg;
                    a_q   <= a_mag;
                    b_q   <= b_mag;
                    prod  <= {{XLEN{1'b0}}, b_mag};
`ifdef NANOV_MULDIV_DIV_EN
                    rem   <= '0;
                    b_nz  <= |b_q;
`endif
                    state <= CALC;
                end
                CALC: begin
`ifdef NANOV_MULDIV_DIV_EN
                    if (is_div(op_q)) begin
                        if (trial[XLEN]) begin
                            rem <= {rem[XLEN-2:0], a_q[XLEN-1]};
                        end else begin
                            rem <= trial[XLEN-1:0];
                        end
                        a_q <= {a_q[XLEN-2:0], ~trial[XLEN]};
                    end else begin
                        prod <= prod_nxt;
                    end
`else
                    prod <= prod_nxt;
`endif
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= FIX;
                    end
                end
                FIX: begin
                    res          <= res_sel;
                    result_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    // zero fill leaves res cleared once the last bit has gone out
                    res <= {1'b0, res[XLEN-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        cnt          <= '0;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nanov_muldiv.sv
// Self-checking bench for nanov_muldiv (XLEN=32): directed vectors, handshake/reset corners, random ops vs. model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nanov_muldiv;
    import nanov_muldiv_pkg::*;

    localparam int XLEN     = 32;
    localparam int T_RISE   = 2*XLEN + 2;
    localparam int T_LAST   = 3*XLEN + 1;
    localparam int T_FALL   = 3*XLEN + 2;
`ifdef NANOV_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [2:0] op;
    logic       a_in;
    logic       b_in;
    logic       busy;
    logic       result_valid;
    logic       result_out;

    int tests = 0;
    int fails = 0;

    nanov_muldiv #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .op           (op),
        .a_in         (a_in),
        .b_in         (b_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_out   (result_out)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V M semantics computed with plain wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pa;
        logic [63:0] pb;
        logic [63:0] p;
        int          sa;
        int          sb;
        logic [31:0] r;
        pa = (f == OP_MULH || f == OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
        pb = (f == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = pa * pb;
        sa = a;
        sb = b;
        r  = 32'h0;
        case (f)
            OP_MUL:                      r = p[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: r = p[63:32];
            OP_DIV: begin
                if (b == 0)                                     r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else                                            r = sa / sb;
            end
            OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0)                                     r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else                                            r = sa % sb;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        if (f[2] && !DIV_EN) r = 32'h0;
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Drives one operation starting at the current negedge (cycle 0) and records what the DUT shows.
    // Returns at the negedge of the first cycle after start with busy low, or right after asserting
    // reset in cycle rst_at. fall stays -1 if the cycle budget runs out.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int restart_at, input int rst_at,
                          output logic [31:0] res, output int rise, output int nvalid,
                          output int lastv, output int fall, output logic busy0, output logic busy1);
        logic [31:0] a_sh;
        logic [31:0] b_sh;
        a_sh = a; b_sh = b;
        res = '0; rise = -1; nvalid = 0; lastv = -1; fall = -1; busy0 = busy; busy1 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) busy1 = busy;
            if (k > 0 && !busy) begin
                fall  = k;
                start = 1'b0;
                return;
            end
            if (result_valid) begin
                res = {result_out, res[31:1]};
                if (rise < 0) rise = k;
                lastv = k;
                nvalid++;
            end
            start = (k == 0) || (k == restart_at);
            op    = (k == 0) ? f : 3'($urandom);
            if (k < 32) begin
                a_in = a_sh[0]; b_in = b_sh[0];
                a_sh = a_sh >> 1; b_sh = b_sh >> 1;
            end else begin
                a_in = 1'($urandom); b_in = 1'($urandom);
            end
            if (k == rst_at) begin
                start = 1'b0;
                rstn  = 1'b0;
                return;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; op = 3'd0; a_in = 1'b0; b_in = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        tests++; if (result_out !== 1'b0) begin fails++; $display("FAIL reset_out: got %b expected 0", result_out); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_timing();
        logic [31:0] res; int rise, nv, lastv, fall; logic b0, b1;
        @(negedge clk);
        run_op(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, -1, -1, res, rise, nv, lastv, fall, b0, b1);
        tests++; if (res !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
        tests++; if (rise != T_RISE) begin fails++; $display("FAIL valid_rise: got %0d expected %0d", rise, T_RISE); end
        tests++; if (nv != XLEN) begin fails++; $display("FAIL valid_len: got %0d expected %0d", nv, XLEN); end
        tests++; if (lastv != T_LAST) begin fails++; $display("FAIL valid_last: got %0d expected %0d", lastv, T_LAST); end
        tests++; if (fall != T_FALL) begin fails++; $display("FAIL busy_fall: got %0d expected %0d", fall, T_FALL); end
        tests++; if (b0 !== 1'b0) begin fails++; $display("FAIL busy_cycle0: got %b expected 0", b0); end
        tests++; if (b1 !== 1'b1) begin fails++; $display("FAIL busy_cycle1: got %b expected 1", b1); end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        logic [31:0] res; int rise, nv, lastv, fall; logic b0, b1;
        v.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        v.push_back('{OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000});
        v.push_back('{OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        v.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'h0});
        v.push_back('{OP_REM,    32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'h0});
        v.push_back('{OP_DIVU,   32'd100, 32'd7, DIV_EN ? 32'd14 : 32'h0});
        v.push_back('{OP_REMU,   32'd100, 32'd7, DIV_EN ? 32'd2 : 32'h0});
        v.push_back('{OP_DIV,    32'h1234_5678, 32'h0, DIV_EN ? 32'hFFFF_FFFF : 32'h0});
        v.push_back('{OP_DIVU,   32'h1234_5678, 32'h0, DIV_EN ? 32'hFFFF_FFFF : 32'h0});
        v.push_back('{OP_REM,    32'h1234_5678, 32'h0, DIV_EN ? 32'h1234_5678 : 32'h0});
        v.push_back('{OP_REMU,   32'h1234_5678, 32'h0, DIV_EN ? 32'h1234_5678 : 32'h0});
        v.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'h0});
        v.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
        v.push_back('{OP_MUL,    32'd6, 32'd7, 32'd42});
        v.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        foreach (v[i]) begin
            @(negedge clk);
            run_op(v[i].f, v[i].a, v[i].b, -1, -1, res, rise, nv, lastv, fall, b0, b1);
            tests++;
            if (res !== v[i].e) begin
                fails++; $display("FAIL directed_%0d op%0d: got %h expected %h", i, v[i].f, res, v[i].e);
            end
            tests++;
            if (rise != T_RISE || nv != XLEN || fall != T_FALL) begin
                fails++; $display("FAIL directed_timing_%0d: rise/len/fall %0d/%0d/%0d expected %0d/%0d/%0d",
                                  i, rise, nv, fall, T_RISE, XLEN, T_FALL);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] res; int rise, nv, lastv, fall; logic b0, b1;
        @(negedge clk);
        run_op(OP_MULH, 32'hFFFF_FFF9, 32'h0000_0003, 10, -1, res, rise, nv, lastv, fall, b0, b1);
        tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL restart_load: got %h expected ffffffff", res); end
        tests++; if (fall != T_FALL) begin fails++; $display("FAIL restart_load_fall: got %0d expected %0d", fall, T_FALL); end
        @(negedge clk);
        run_op(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 70, -1, res, rise, nv, lastv, fall, b0, b1);
        tests++; if (res !== 32'hFFFF_FFEB) begin fails++; $display("FAIL restart_out: got %h expected ffffffeb", res); end
        tests++; if (fall != T_FALL) begin fails++; $display("FAIL restart_out_fall: got %0d expected %0d", fall, T_FALL); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res; int rise, nv, lastv, fall; logic b0, b1;
        @(negedge clk);
        run_op(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, -1, 40, res, rise, nv, lastv, fall, b0, b1);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst40_busy: got %b expected 0", busy); end
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL rst40_valid: got %b expected 0", result_valid); end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 70, res, rise, nv, lastv, fall, b0, b1);
        tests++; if (nv != 5) begin fails++; $display("FAIL rst70_seen: got %0d expected 5", nv); end
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst70_busy: got %b expected 0", busy); end
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL rst70_valid: got %b expected 0", result_valid); end
        tests++; if (result_out !== 1'b0) begin fails++; $display("FAIL rst70_out: got %b expected 0", result_out); end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, res, rise, nv, lastv, fall, b0, b1);
        tests++; if (res !== 32'hFFFF_FFFE) begin fails++; $display("FAIL post_reset_mulhu: got %h expected fffffffe", res); end
        tests++; if (fall != T_FALL) begin fails++; $display("FAIL post_reset_fall: got %0d expected %0d", fall, T_FALL); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, a, b, e; logic [2:0] f; int rise, nv, lastv, fall; logic b0, b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            f = 3'($urandom); a = pick(); b = pick(); e = model(f, a, b);
            run_op(f, a, b, -1, -1, res, rise, nv, lastv, fall, b0, b1);
            tests++;
            if (res !== e || fall != T_FALL || b0 !== 1'b0) begin
                fails++; $display("FAIL b2b_%0d op%0d a=%h b=%h: got %h fall %0d expected %h fall %0d",
                                  i, f, a, b, res, fall, e, T_FALL);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, e; logic [2:0] f; int rise, nv, lastv, fall; logic b0, b1;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom); a = pick(); b = pick(); e = model(f, a, b);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(f, a, b, -1, -1, res, rise, nv, lastv, fall, b0, b1);
            tests++;
            if (res !== e) begin
                fails++; $display("FAIL rand_%0d op%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, e);
            end
            tests++;
            if (rise != T_RISE || nv != XLEN || fall != T_FALL) begin
                fails++; $display("FAIL rand_timing_%0d: rise/len/fall %0d/%0d/%0d expected %0d/%0d/%0d",
                                  i, rise, nv, fall, T_RISE, XLEN, T_FALL);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_directed();
        test_start_while_busy();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
